// File: rtl/srlatch_pulse_sched.sv
// Round-robin scheduler driving a bank of NAND-form SR latches with timed,
// non-overlapping active-low pulses. Optional feature macro: SRLATCH_SCHED_VERIFY_EN.
module srlatch_pulse_sched #(
  parameter int N       = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N-1:0]                      set_req,
  input  logic [N-1:0]                      rst_req,
`ifdef SRLATCH_SCHED_VERIFY_EN
  input  logic [N-1:0]                      q,
  output logic                              verify_err,
`endif
  output logic [N-1:0]                      s_n,
  output logic [N-1:0]                      r_n,
  output logic                              busy,
  output logic                              done,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] done_idx,
  output logic                              conflict
);

  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   pending_set, pending_rst;
  logic [N-1:0]   nxt_set, nxt_rst, clr;
  logic [IW-1:0]  rr_ptr, g_idx, gnt_idx;
  logic           g_set, gnt_found;

  // First pending index at or after rr_ptr, wrapping modulo N.
  always_comb begin
    int unsigned cand;
    logic [IW-1:0] cand_i;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand   = (32'(rr_ptr) + k) % N;
      cand_i = IW'(cand);
      if (!gnt_found && (pending_set[cand_i] || pending_rst[cand_i])) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_i;
      end
    end
  end

  // Grant clears its bit first so a same-cycle request survives as fresh pending.
  always_comb begin
    clr     = (state == S_IDLE && gnt_found) ? (ONE << gnt_idx) : '0;
    nxt_set = (set_req & ~rst_req) | (pending_set & ~clr & ~set_req & ~rst_req);
    nxt_rst = (rst_req & ~set_req) | (pending_rst & ~clr & ~set_req & ~rst_req);
  end

`ifdef SRLATCH_SCHED_VERIFY_EN
  logic first_gap;
  assign verify_err = first_gap & (q[g_idx] != g_set);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      s_n         <= '1;
      r_n         <= '1;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_idx    <= '0;
      conflict    <= 1'b0;
      pending_set <= '0;
      pending_rst <= '0;
      rr_ptr      <= '0;
      g_idx       <= '0;
      g_set       <= 1'b0;
`ifdef SRLATCH_SCHED_VERIFY_EN
      first_gap   <= 1'b0;
`endif
    end else begin
      pending_set <= nxt_set;
      pending_rst <= nxt_rst;
      conflict    <= |(set_req & rst_req);
      done        <= 1'b0;
`ifdef SRLATCH_SCHED_VERIFY_EN
      first_gap   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            g_idx <= gnt_idx;
            g_set <= pending_set[gnt_idx];
            cnt   <= CW'(PULSE_W - 1);
            busy  <= 1'b1;
            state <= S_PULSE;
            if (pending_set[gnt_idx]) s_n <= ~(ONE << gnt_idx);
            else                      r_n <= ~(ONE << gnt_idx);
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            s_n   <= '1;
            r_n   <= '1;
            cnt   <= CW'(GAP_W - 1);
            state <= S_GAP;
`ifdef SRLATCH_SCHED_VERIFY_EN
            first_gap <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            done_idx <= g_idx;
            rr_ptr   <= (g_idx == IW'(N - 1)) ? '0 : g_idx + 1'b1;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srlatch_pulse_sched.sv
// Bench for srlatch_pulse_sched: directed table, hand sequences and random
// traffic against a timeline-based reference model.
module tb_srlatch_pulse_sched;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int GW = 1;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  set_req = '0, rst_req = '0;
  logic [N-1:0]  s_n, r_n;
  logic          busy, done, conflict;
  logic [IW-1:0] done_idx;

  int vectors = 0;
  int errors  = 0;

`ifdef SRLATCH_SCHED_VERIFY_EN
  logic [N-1:0] q, qlat = '0;
  logic         verify_err;
  logic         q_tie = 1'b0;
  always @(s_n or r_n)
    for (int i = 0; i < N; i++) begin
      if (!s_n[i])      qlat[i] = 1'b1;
      else if (!r_n[i]) qlat[i] = 1'b0;
    end
  assign q = q_tie ? '0 : qlat;
`endif

  srlatch_pulse_sched #(.N(N), .PULSE_W(PW), .GAP_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .rst_req(rst_req),
`ifdef SRLATCH_SCHED_VERIFY_EN
    .q(q), .verify_err(verify_err),
`endif
    .s_n(s_n), .r_n(r_n), .busy(busy), .done(done), .done_idx(done_idx),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  // Reference model: pending kinds per index plus the edge number of the
  // current grant; outputs follow from elapsed edges since that grant.
  int pend[N];            // 0 none, 1 set, 2 reset
  int rr, e, ge, gidx, gkind;
  bit active;
  logic [N-1:0]  ms, mr;
  logic          mb, md, mc, mv;
  logic [IW-1:0] mi;

  task automatic model_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    rr = 0; e = 0; ge = 0; gidx = 0; gkind = 0; active = 0;
    ms = '1; mr = '1; mb = 0; md = 0; mc = 0; mi = '0; mv = 0;
  endtask

  task automatic model_step(input logic [N-1:0] s, input logic [N-1:0] r);
    int j;
    bit idle_before;
    e++;
    idle_before = !active || (e > ge + PW + GW);
    if (active && e == ge + PW + GW) rr = (gidx + 1) % N;
    if (idle_before) begin
      active = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr + k) % N;
        if (!active && pend[c] != 0) begin
          active = 1; ge = e; gidx = c; gkind = pend[c]; pend[c] = 0;
        end
      end
    end
    mc = |(s & r);
    for (int i = 0; i < N; i++) begin
      if (s[i] && r[i]) pend[i] = 0;
      else if (s[i])    pend[i] = 1;
      else if (r[i])    pend[i] = 2;
    end
    ms = '1; mr = '1; mb = 0; md = 0; mi = '0; mv = 0;
    if (active) begin
      j = e - ge;
      if (j < PW) begin
        if (gkind == 1) ms[gidx] = 1'b0;
        else            mr[gidx] = 1'b0;
      end
      if (j < PW + GW) mb = 1;
      if (j == PW + GW) begin md = 1; mi = IW'(gidx); end
`ifdef SRLATCH_SCHED_VERIFY_EN
      if (j == PW) mv = (q[gidx] != (gkind == 1));
`endif
    end
  endtask

  task automatic check(input string name, input logic [N-1:0] es, input logic [N-1:0] er,
                       input logic eb, input logic ed, input logic [IW-1:0] ei, input logic ec);
    bit ok;
    vectors++;
    ok = (s_n === es) && (r_n === er) && (busy === eb) && (done === ed) &&
         (conflict === ec) && (!ed || done_idx === ei) && ((~s_n & ~r_n) == '0) &&
         ($countones(~s_n) + $countones(~r_n) <= 1);
    if (!ok) begin
      errors++;
      $display("FAIL %s @%0t: got s_n=%b r_n=%b busy=%b done=%b idx=%0d conflict=%b; want s_n=%b r_n=%b busy=%b done=%b idx=%0d conflict=%b",
               name, $time, s_n, r_n, busy, done, done_idx, conflict, es, er, eb, ed, ei, ec);
    end
`ifdef SRLATCH_SCHED_VERIFY_EN
    vectors++;
    if (verify_err !== mv) begin
      errors++;
      $display("FAIL %s verify_err @%0t: got %b want %b", name, $time, verify_err, mv);
    end
`endif
  endtask

  task automatic cycle(input logic [N-1:0] s, input logic [N-1:0] r);
    set_req = s; rst_req = r;
    @(posedge clk);
    model_step(s, r);
    @(negedge clk);
    set_req = '0; rst_req = '0;
  endtask

  typedef struct {
    logic [N-1:0]  s, r, es, er;
    logic          eb, ed;
    logic [IW-1:0] ei;
    logic          ec;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] s, input logic [N-1:0] r,
                              input logic [N-1:0] es, input logic [N-1:0] er,
                              input logic eb, input logic ed, input logic [IW-1:0] ei,
                              input logic ec);
    vec_t v;
    v.s = s; v.r = r; v.es = es; v.er = er; v.eb = eb; v.ed = ed; v.ei = ei; v.ec = ec;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    // set[0] + rst[3] together with rr_ptr at 0: index 0 then index 3
    tbl[0]  = mk(4'b0001, 4'b1000, 4'b1111, 4'b1111, 0, 0, 0, 0);
    tbl[1]  = mk(4'b0000, 4'b0000, 4'b1110, 4'b1111, 1, 0, 0, 0);
    tbl[2]  = mk(4'b0000, 4'b0000, 4'b1110, 4'b1111, 1, 0, 0, 0);
    tbl[3]  = mk(4'b0000, 4'b0000, 4'b1111, 4'b1111, 1, 0, 0, 0);
    tbl[4]  = mk(4'b0000, 4'b0000, 4'b1111, 4'b1111, 0, 1, 0, 0);
    tbl[5]  = mk(4'b0000, 4'b0000, 4'b1111, 4'b0111, 1, 0, 0, 0);
    tbl[6]  = mk(4'b0000, 4'b0000, 4'b1111, 4'b0111, 1, 0, 0, 0);
    tbl[7]  = mk(4'b0000, 4'b0000, 4'b1111, 4'b1111, 1, 0, 0, 0);
    tbl[8]  = mk(4'b0000, 4'b0000, 4'b1111, 4'b1111, 0, 1, 3, 0);
    tbl[9]  = mk(4'b0000, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 0);
    // single set on index 2
    tbl[10] = mk(4'b0100, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 0);
    tbl[11] = mk(4'b0000, 4'b0000, 4'b1011, 4'b1111, 1, 0, 0, 0);
    tbl[12] = mk(4'b0000, 4'b0000, 4'b1011, 4'b1111, 1, 0, 0, 0);
    tbl[13] = mk(4'b0000, 4'b0000, 4'b1111, 4'b1111, 1, 0, 0, 0);
    tbl[14] = mk(4'b0000, 4'b0000, 4'b1111, 4'b1111, 0, 1, 2, 0);
    tbl[15] = mk(4'b0000, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 0);
    // simultaneous set/reset on index 1: conflict, no service
    tbl[16] = mk(4'b0010, 4'b0010, 4'b1111, 4'b1111, 0, 0, 0, 1);
    tbl[17] = mk(4'b0000, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 0);
    tbl[18] = mk(4'b0000, 4'b0000, 4'b1111, 4'b1111, 0, 0, 0, 0);

    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", '1, '1, 0, 0, 0, 0);
    vectors++;
    if (done_idx !== '0) begin
      errors++;
      $display("FAIL reset_done_idx: got %0d want 0", done_idx);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cycle('0, '0);
      check("idle", ms, mr, mb, md, mi, mc);
    end

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].s, tbl[i].r);
      check($sformatf("table[%0d]", i), tbl[i].es, tbl[i].er, tbl[i].eb, tbl[i].ed,
            tbl[i].ei, tbl[i].ec);
    end

    // Reset in the middle of a pulse on index 2, with index 0 also pending
    cycle(4'b0100, '0);
    check("pre_abort_req", ms, mr, mb, md, mi, mc);
    cycle('0, 4'b0001);
    check("abort_pulse", 4'b1011, 4'b1111, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check("async_abort", '1, '1, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle('0, '0);
      check("after_abort", ms, mr, mb, md, mi, mc);
    end

`ifdef SRLATCH_SCHED_VERIFY_EN
    q_tie = 1'b1;
    cycle(4'b0010, '0);
    for (int i = 0; i < 5; i++) begin
      cycle('0, '0);
      check("verify_tied", ms, mr, mb, md, mi, mc);
    end
    q_tie = 1'b0;
    cycle(4'b0010, '0);
    for (int i = 0; i < 5; i++) begin
      cycle('0, '0);
      check("verify_follow", ms, mr, mb, md, mi, mc);
    end
`endif

    for (int n = 0; n < 600; n++) begin
      logic [N-1:0] s, r;
      for (int b = 0; b < N; b++) begin
        s[b] = ($urandom_range(0, 6) == 0);
        r[b] = ($urandom_range(0, 6) == 0);
      end
      cycle(s, r);
      check("random", ms, mr, mb, md, mi, mc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
